// File: rtl/quadrature_decoder_if.sv
// Bundles the quadrature pins, the count controls and the decoded position outputs.
// master drives the pins and controls; slave is the decoder.
interface quadrature_decoder_if #(
    parameter int N = 4
);
    logic         a_in;
    logic         b_in;
    logic         en;
    logic         clr;
    logic [N-1:0] count;
    logic         dir;
    logic         step;
    logic         err;

    modport master (output a_in, b_in, en, clr, input count, dir, step, err);
    modport slave  (input a_in, b_in, en, clr, output count, dir, step, err);
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: 2-flop sync, FILT-cycle glitch filter, gray-step decode into a wrapping counter.
// Latency: pin change first sampled at edge k shows on count/step/err after edge k+1+FILT; no backpressure.
module quadrature_decoder #(
    parameter int N    = 4,
    parameter int FILT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    quadrature_decoder_if.slave  qif
);
    localparam logic [4:0] FILT_W = 5'(FILT);

    logic [1:0]   sync1_q, sync1_d;
    logic [1:0]   sync2_q, sync2_d;
    logic [1:0]   prev_q,  prev_d;
    logic [1:0]   filt_q,  filt_d;
    logic [3:0]   stab_q,  stab_d;
    logic         first_q, first_d;
    logic [N-1:0] count_q, count_d;
    logic         dir_q,   dir_d;
    logic         step_q,  step_d;
    logic         err_q,   err_d;

    logic [4:0]   stab_n;
    logic         accept;
    logic         is_up;
    logic         is_dn;

    function automatic logic [1:0] up_next(input logic [1:0] s);
        case (s)
            2'b00:   up_next = 2'b01;
            2'b01:   up_next = 2'b11;
            2'b11:   up_next = 2'b10;
            default: up_next = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] dn_next(input logic [1:0] s);
        case (s)
            2'b00:   dn_next = 2'b10;
            2'b10:   dn_next = 2'b11;
            2'b11:   dn_next = 2'b01;
            default: dn_next = 2'b00;
        endcase
    endfunction

    always_comb begin
        sync1_d = {qif.a_in, qif.b_in};
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // Any change in the synchronized pair restarts the run length at one.
        stab_n  = (sync2_q != prev_q) ? 5'd1 : ({1'b0, stab_q} + 5'd1);
        accept  = (sync2_q != filt_q) && (stab_n >= FILT_W);
        stab_d  = (accept || (sync2_q == filt_q)) ? 4'd0 : stab_n[3:0];
        filt_d  = accept ? sync2_q : filt_q;
        first_d = first_q && !accept;

        is_up   = (sync2_q == up_next(filt_q));
        is_dn   = (sync2_q == dn_next(filt_q));

        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        if (accept && !first_q && qif.en) begin
            if (is_up) begin
                count_d = count_q + N'(1);
                dir_d   = 1'b1;
                step_d  = 1'b1;
            end else if (is_dn) begin
                count_d = count_q - N'(1);
                dir_d   = 1'b0;
                step_d  = 1'b1;
            end else begin
                err_d   = 1'b1;
            end
        end
        if (qif.clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
            filt_q  <= 2'b00;
            stab_q  <= 4'd0;
            first_q <= 1'b1;
            count_q <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            filt_q  <= filt_d;
            stab_q  <= stab_d;
            first_q <= first_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign qif.count = count_q;
    assign qif.dir   = dir_q;
    assign qif.step  = step_q;
    assign qif.err   = err_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder (N=4, FILT=2): expectations queued at drive time, popped on output.
module tb_quadrature_decoder;
    localparam int N    = 4;
    localparam int FILT = 2;

    typedef struct {
        logic [N-1:0] count;
        logic         dir;
        logic         step;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   step_tot = 0;
    int   err_tot  = 0;
    int   both_hi  = 0;

    exp_t         exp_q[$];
    logic [N-1:0] cnt_m;
    logic         dir_m;
    logic [1:0]   filt_m;
    logic         first_m;
    logic         en_m;

    quadrature_decoder_if #(.N(N)) qif();

    quadrature_decoder #(.N(N), .FILT(FILT)) dut (
        .clk (clk),
        .rst (rst),
        .qif (qif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            step_tot += int'(qif.step);
            err_tot  += int'(qif.err);
            if (qif.step && qif.err) both_hi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] up_of(input logic [1:0] s);
        case (s)
            2'b00:   up_of = 2'b01;
            2'b01:   up_of = 2'b11;
            2'b11:   up_of = 2'b10;
            default: up_of = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] dn_of(input logic [1:0] s);
        case (s)
            2'b00:   dn_of = 2'b10;
            2'b10:   dn_of = 2'b11;
            2'b11:   dn_of = 2'b01;
            default: dn_of = 2'b00;
        endcase
    endfunction

    // Drive one pin change (called at a negedge), queue the expected result, then collect and compare.
    task automatic move(input logic [1:0] ab, input bit clr_hit);
        exp_t e;
        exp_t got;
        bit   seen;
        int   lat;
        logic obs_step;
        logic obs_err;
        e.step = 1'b0;
        e.err  = 1'b0;
        if (first_m) begin
            first_m = 1'b0;
        end else if (en_m) begin
            if (ab == up_of(filt_m)) begin
                cnt_m = cnt_m + 4'd1; dir_m = 1'b1; e.step = 1'b1;
            end else if (ab == dn_of(filt_m)) begin
                cnt_m = cnt_m - 4'd1; dir_m = 1'b0; e.step = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end
        if (clr_hit) cnt_m = '0;
        filt_m  = ab;
        e.count = cnt_m;
        e.dir   = dir_m;
        exp_q.push_back(e);

        qif.a_in = ab[1];
        qif.b_in = ab[0];
        seen = 0; lat = 0; obs_step = 0; obs_err = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            if (clr_hit && c == FILT + 2) qif.clr = 1'b1;
            @(posedge clk);
            @(negedge clk);
            qif.clr = 1'b0;
            if (qif.step || qif.err) begin
                seen = 1; lat = c; obs_step = qif.step; obs_err = qif.err;
            end
        end

        got = exp_q.pop_front();
        check("event_seen", 32'(seen), 32'(got.step | got.err));
        if (seen) begin
            check("latency", 32'(lat), 32'(FILT + 2));
            check("step", 32'(obs_step), 32'(got.step));
            check("err", 32'(obs_err), 32'(got.err));
            check("count", 32'(qif.count), 32'(got.count));
            check("dir", 32'(qif.dir), 32'(got.dir));
            @(posedge clk);
            @(negedge clk);
            check("pulse_one_cycle", 32'({qif.step, qif.err}), 32'd0);
        end else begin
            check("count_noevent", 32'(qif.count), 32'(got.count));
            check("dir_noevent", 32'(qif.dir), 32'(got.dir));
        end
    endtask

    task automatic do_clr();
        qif.clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        qif.clr = 1'b0;
        cnt_m = '0;
        check("clr_count", 32'(qif.count), 32'd0);
    endtask

    initial begin
        int s0;
        int e0;
        logic [1:0] hold;

        rst = 1'b1;
        qif.a_in = 1'b0; qif.b_in = 1'b1; qif.en = 1'b1; qif.clr = 1'b0;
        cnt_m = '0; dir_m = 1'b1; filt_m = 2'b00; first_m = 1'b1; en_m = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count", 32'(qif.count), 32'd0);
        check("rst_dir", 32'(qif.dir), 32'd1);
        check("rst_step", 32'(qif.step), 32'd0);
        check("rst_err", 32'(qif.err), 32'd0);
        rst = 1'b0;

        // First acceptance after reset only loads 01.
        s0 = step_tot;
        move(2'b01, 0);
        check("first_load_steps", 32'(step_tot - s0), 32'd0);

        move(2'b00, 0);
        do_clr();

        // 20 up steps from 00 with wrap.
        s0 = step_tot; e0 = err_tot;
        for (int i = 0; i < 20; i++) begin
            move(up_of(filt_m), 0);
            if (i == 15) check("wrap_to_zero", 32'(qif.count), 32'd0);
        end
        check("up20_count", 32'(qif.count), 32'd4);
        check("up20_dir", 32'(qif.dir), 32'd1);
        check("up20_steps", 32'(step_tot - s0), 32'd20);
        check("up20_errs", 32'(err_tot - e0), 32'd0);

        // Three down steps from zero.
        do_clr();
        for (int i = 0; i < 3; i++) move(dn_of(filt_m), 0);
        check("down3_count", 32'(qif.count), 32'd13);
        check("down3_dir", 32'(qif.dir), 32'd0);

        // Illegal 00 -> 11, then a legal step from 11.
        move(2'b00, 0);
        move(2'b11, 0);
        check("illegal_count", 32'(qif.count), 32'd12);
        move(2'b10, 0);
        check("after_illegal_count", 32'(qif.count), 32'd13);

        // One-cycle glitch on a_in must vanish.
        s0 = step_tot; e0 = err_tot;
        hold = filt_m;
        qif.a_in = ~hold[1];
        @(posedge clk);
        @(negedge clk);
        qif.a_in = hold[1];
        repeat (10) @(negedge clk);
        check("glitch_steps", 32'(step_tot - s0), 32'd0);
        check("glitch_errs", 32'(err_tot - e0), 32'd0);
        check("glitch_count", 32'(qif.count), 32'd13);

        // clr on the accept edge of an up step.
        move(2'b00, 1);

        // Disabled counting still tracks the pins.
        qif.en = 1'b0; en_m = 1'b0;
        s0 = step_tot;
        for (int i = 0; i < 4; i++) move(up_of(filt_m), 0);
        qif.en = 1'b1; en_m = 1'b1;
        move(up_of(filt_m), 0);
        check("en_steps", 32'(step_tot - s0), 32'd1);
        check("en_count", 32'(qif.count), 32'd1);

        // Reset in the middle of filtering a step.
        s0 = step_tot;
        qif.a_in = 1'b1; qif.b_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_count", 32'(qif.count), 32'd0);
        check("midrst_dir", 32'(qif.dir), 32'd1);
        rst = 1'b0;
        cnt_m = '0; dir_m = 1'b1; filt_m = 2'b00; first_m = 1'b1;
        move(2'b11, 0);
        check("midrst_steps", 32'(step_tot - s0), 32'd0);
        move(2'b10, 0);
        check("midrst_recount", 32'(qif.count), 32'd1);

        check("step_err_exclusive", 32'(both_hi), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
